// File: rtl/fastica_sample_engine.sv
// fastica_sample_engine
//   Sample store and sequencer for the FastICA datapath. Captures DEPTH whitened
//   samples of CH channels, replays them for a programmable number of passes over
//   a valid/ready link, and computes the demix y = W*z for every stored sample.
// Ports
//   clk_fastica, rst_fastica        clock (rising edge), async active-high reset
//   cap_start, z_valid, z_in        capture command and sample input
//   cap_done                        store full (FULL state)
//   rep_start, rep_passes           replay command, pass count (0 behaves as 1)
//   rep_valid/ready/data/idx        replay beat stream
//   rep_last, rep_pass_last         beat at index DEPTH-1 / final beat of final pass
//   dmx_start, w_in                 demix command, W matrix (snapshotted at start)
//   y_valid, y_ready, y_out         demixed sample stream
//   busy                            CAPTURE, REPLAY or demix in progress
//   cmd_err                         one-cycle pulse when a start command is rejected
module fastica_sample_engine #(
  parameter int DW    = 26,
  parameter int CH    = 4,
  parameter int DEPTH = 128,
  parameter int FRAC  = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk_fastica,
  input  logic                  rst_fastica,
  input  logic                  cap_start,
  input  logic                  z_valid,
  input  logic [CH*DW-1:0]      z_in,
  output logic                  cap_done,
  input  logic                  rep_start,
  input  logic [7:0]            rep_passes,
  output logic                  rep_valid,
  input  logic                  rep_ready,
  output logic [CH*DW-1:0]      rep_data,
  output logic [AW-1:0]         rep_idx,
  output logic                  rep_last,
  output logic                  rep_pass_last,
  input  logic                  dmx_start,
  input  logic [CH*CH*DW-1:0]   w_in,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [CH*DW-1:0]      y_out,
  output logic                  busy,
  output logic                  cmd_err
);

  localparam int RW   = $clog2(CH);
  localparam int ACCW = 2*DW + $clog2(CH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH-1);
  localparam logic [RW-1:0] LAST_ROW = RW'(CH-1);
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_FULL, S_REPLAY, S_DMX_CALC, S_DMX_OUT
  } state_e;

  state_e                 state_q;
  logic [AW-1:0]          cnt_q;
  logic [AW-1:0]          idx_q;
  logic [7:0]             pass_q;
  logic [7:0]             passes_q;
  logic [RW-1:0]          row_q;
  logic [CH*CH*DW-1:0]    wsnap_q;
  logic [CH*DW-1:0]       ycalc_q;
  logic [CH*DW-1:0]       y_q;
  logic [CH*DW-1:0]       rep_data_q;
  logic                   cmd_err_q;

  logic [CH*DW-1:0]       mem_q [DEPTH];

  logic                   mem_we_d;
  logic                   at_end_d;
  logic                   last_pass_d;
  logic [AW-1:0]          idx_next_d;
  logic [CH*DW-1:0]       z_cur_d;
  logic [CH*DW-1:0]       rep_next_d;
  logic [CH*DW-1:0]       rep_first_d;
  logic signed [DW-1:0]   wj_d;
  logic signed [DW-1:0]   zj_d;
  logic signed [2*DW-1:0] prod_d;
  logic signed [ACCW-1:0] acc_d;
  logic signed [ACCW-1:0] shifted_d;
  logic [DW-1:0]          y_row_d;
  logic [CH*DW-1:0]       y_full_d;

  // A restart in CAPTURE drops the sample presented in the same cycle.
  assign mem_we_d    = (state_q == S_CAPTURE) && z_valid && !cap_start;
  assign at_end_d    = (idx_q == LAST_IDX);
  assign last_pass_d = (pass_q == (passes_q - 8'd1));
  assign idx_next_d  = at_end_d ? '0 : idx_q + 1'b1;
  assign z_cur_d     = mem_q[idx_q];
  assign rep_next_d  = mem_q[idx_next_d];
  assign rep_first_d = mem_q[0];

  always_ff @(posedge clk_fastica) begin
    if (mem_we_d) begin
      mem_q[cnt_q] <= z_in;
    end
  end

  // One demix row per cycle: full-precision dot product, floor shift, saturate.
  always_comb begin
    wj_d      = '0;
    zj_d      = '0;
    prod_d    = '0;
    acc_d     = '0;
    for (int unsigned j = 0; j < CH; j++) begin
      wj_d   = wsnap_q[(32'(row_q)*CH + j)*DW +: DW];
      zj_d   = z_cur_d[j*DW +: DW];
      prod_d = (2*DW)'(wj_d) * (2*DW)'(zj_d);
      acc_d  = acc_d + ACCW'(prod_d);
    end
    shifted_d = acc_d >>> FRAC;
    if (shifted_d > SAT_MAX) begin
      y_row_d = SAT_MAX[DW-1:0];
    end else if (shifted_d < SAT_MIN) begin
      y_row_d = SAT_MIN[DW-1:0];
    end else begin
      y_row_d = shifted_d[DW-1:0];
    end
    y_full_d = ycalc_q;
    y_full_d[(CH-1)*DW +: DW] = y_row_d;
  end

  always_ff @(posedge clk_fastica or posedge rst_fastica) begin
    if (rst_fastica) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      pass_q     <= '0;
      passes_q   <= '0;
      row_q      <= '0;
      wsnap_q    <= '0;
      ycalc_q    <= '0;
      y_q        <= '0;
      rep_data_q <= '0;
      cmd_err_q  <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;

      case (state_q)
        S_CAPTURE: begin
          if (z_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
              state_q <= S_FULL;
            end
          end
        end
        S_REPLAY: begin
          if (rep_ready) begin
            if (at_end_d && last_pass_d) begin
              state_q <= S_FULL;
              idx_q   <= '0;
              pass_q  <= '0;
            end else begin
              idx_q      <= idx_next_d;
              rep_data_q <= rep_next_d;
              if (at_end_d) begin
                pass_q <= pass_q + 8'd1;
              end
            end
          end
        end
        S_DMX_CALC: begin
          ycalc_q[32'(row_q)*DW +: DW] <= y_row_d;
          if (row_q == LAST_ROW) begin
            y_q     <= y_full_d;
            row_q   <= '0;
            state_q <= S_DMX_OUT;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        S_DMX_OUT: begin
          if (y_ready) begin
            if (at_end_d) begin
              idx_q   <= '0;
              state_q <= S_FULL;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_DMX_CALC;
            end
          end
        end
        default: ;
      endcase

      // Commands are evaluated after the state actions so an accepted start
      // overrides them; only the highest-priority start is considered.
      if (cap_start) begin
        if (state_q == S_IDLE || state_q == S_FULL || state_q == S_CAPTURE) begin
          state_q <= S_CAPTURE;
          cnt_q   <= '0;
        end else begin
          cmd_err_q <= 1'b1;
        end
      end else if (rep_start) begin
        if (state_q == S_FULL) begin
          state_q    <= S_REPLAY;
          idx_q      <= '0;
          pass_q     <= '0;
          passes_q   <= (rep_passes == 8'd0) ? 8'd1 : rep_passes;
          rep_data_q <= rep_first_d;
        end else begin
          cmd_err_q <= 1'b1;
        end
      end else if (dmx_start) begin
        if (state_q == S_FULL) begin
          state_q <= S_DMX_CALC;
          idx_q   <= '0;
          row_q   <= '0;
          wsnap_q <= w_in;
        end else begin
          cmd_err_q <= 1'b1;
        end
      end
    end
  end

  assign cap_done      = (state_q == S_FULL);
  assign busy          = (state_q == S_CAPTURE) || (state_q == S_REPLAY) ||
                         (state_q == S_DMX_CALC) || (state_q == S_DMX_OUT);
  assign rep_valid     = (state_q == S_REPLAY);
  assign rep_last      = rep_valid && at_end_d;
  assign rep_pass_last = rep_valid && at_end_d && last_pass_d;
  assign rep_data      = rep_data_q;
  assign rep_idx       = idx_q;
  assign y_valid       = (state_q == S_DMX_OUT);
  assign y_out         = y_q;
  assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_fastica_sample_engine.sv
// tb_fastica_sample_engine
//   Directed bench for fastica_sample_engine: capture, multi-pass replay, demix
//   (identity and saturating), command arbitration/rejection and async reset.
module tb_fastica_sample_engine;

  localparam int DW    = 26;
  localparam int CH    = 4;
  localparam int DEPTH = 128;
  localparam int FRAC  = 16;
  localparam int AW    = 7;
  localparam int ZW    = CH*DW;
  localparam int WW    = CH*CH*DW;

  localparam logic [ZW-1:0] PIN0   = {26'd3, 26'd2, 26'd1, 26'd0};
  localparam logic [ZW-1:0] PIN127 = {26'd2035, 26'd2034, 26'd2033, 26'd2032};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cap_start = 1'b0;
  logic            z_valid = 1'b0;
  logic [ZW-1:0]   z_in = '0;
  logic            cap_done;
  logic            rep_start = 1'b0;
  logic [7:0]      rep_passes = '0;
  logic            rep_valid;
  logic            rep_ready = 1'b0;
  logic [ZW-1:0]   rep_data;
  logic [AW-1:0]   rep_idx;
  logic            rep_last;
  logic            rep_pass_last;
  logic            dmx_start = 1'b0;
  logic [WW-1:0]   w_in = '0;
  logic            y_valid;
  logic            y_ready = 1'b0;
  logic [ZW-1:0]   y_out;
  logic            busy;
  logic            cmd_err;

  always #5 clk = ~clk;

  fastica_sample_engine #(.DW(DW), .CH(CH), .DEPTH(DEPTH), .FRAC(FRAC), .AW(AW)) dut (
    .clk_fastica(clk), .rst_fastica(rst),
    .cap_start(cap_start), .z_valid(z_valid), .z_in(z_in), .cap_done(cap_done),
    .rep_start(rep_start), .rep_passes(rep_passes), .rep_valid(rep_valid),
    .rep_ready(rep_ready), .rep_data(rep_data), .rep_idx(rep_idx),
    .rep_last(rep_last), .rep_pass_last(rep_pass_last),
    .dmx_start(dmx_start), .w_in(w_in), .y_valid(y_valid), .y_ready(y_ready),
    .y_out(y_out), .busy(busy), .cmd_err(cmd_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: stored samples and expected output streams.
  typedef struct {
    logic [ZW-1:0] data;
    int            idx;
    logic          last;
    logic          plast;
  } beat_t;

  logic [ZW-1:0] mdl_mem [DEPTH];
  beat_t         exp_rep [$];
  logic [ZW-1:0] exp_y   [$];

  function automatic logic [ZW-1:0] demix(input logic [WW-1:0] w, input logic [ZW-1:0] z);
    logic [ZW-1:0]        y;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    longint               s;
    longint               q;
    longint               maxv;
    longint               minv;
    maxv = (longint'(1) <<< (DW-1)) - 1;
    minv = -(longint'(1) <<< (DW-1));
    y = '0;
    for (int r = 0; r < CH; r++) begin
      s = 0;
      for (int j = 0; j < CH; j++) begin
        a = w[(r*CH+j)*DW +: DW];
        b = z[j*DW +: DW];
        s = s + longint'(a) * longint'(b);
      end
      q = s >>> FRAC;
      if (q > maxv) q = maxv;
      if (q < minv) q = minv;
      y[r*DW +: DW] = q[DW-1:0];
    end
    return y;
  endfunction

  // Stream checker: every valid cycle is compared against the head of the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (rep_valid) begin
        if (exp_rep.size() == 0) begin
          chk("rep_valid_unexpected", rep_valid, 1'b0);
        end else begin
          chk("rep_data", rep_data, exp_rep[0].data);
          chk("rep_idx", rep_idx, exp_rep[0].idx);
          chk("rep_last", rep_last, exp_rep[0].last);
          chk("rep_pass_last", rep_pass_last, exp_rep[0].plast);
          if (rep_ready) void'(exp_rep.pop_front());
        end
      end
      if (y_valid) begin
        if (exp_y.size() == 0) begin
          chk("y_valid_unexpected", y_valid, 1'b0);
        end else begin
          chk("y_out", y_out, exp_y[0]);
          if (y_ready) void'(exp_y.pop_front());
        end
      end
    end
  end

  task automatic feed(input bit special);
    for (int k = 0; k < DEPTH; k++) begin
      logic [ZW-1:0] s;
      s = '0;
      repeat ($urandom_range(0, 2)) tick;
      for (int c = 0; c < CH; c++) begin
        if (!special)    s[c*DW +: DW] = DW'(k*16 + c);
        else if (k == 0) s[c*DW +: DW] = (c == 0) ? 26'h1FFFFFF : 26'h0;
        else if (k == 1) s[c*DW +: DW] = (c == 0) ? 26'h2000000 : 26'h0;
        else             s[c*DW +: DW] = DW'($urandom());
      end
      mdl_mem[k] = s;
      z_in = s;
      z_valid = 1'b1;
      tick;
      z_valid = 1'b0;
      if (k == DEPTH-2) chk("cap_done_before_last", cap_done, 1'b0);
      if (k == DEPTH-1) chk("cap_done_after_last", cap_done, 1'b1);
    end
  endtask

  task automatic replay(input int passes, input bit rand_rdy, input bit pin);
    int np, beats, nlast, nplast, guard;
    np = (passes == 0) ? 1 : passes;
    beats = 0; nlast = 0; nplast = 0; guard = 0;
    for (int p = 0; p < np; p++)
      for (int k = 0; k < DEPTH; k++)
        exp_rep.push_back('{mdl_mem[k], k, k == DEPTH-1, (p == np-1) && (k == DEPTH-1)});
    rep_passes = 8'(passes);
    rep_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    rep_start = 1'b1;
    tick;
    rep_start = 1'b0;
    while (exp_rep.size() > 0 && guard < 5000) begin
      if (rep_valid && rep_ready) begin
        beats++;
        nlast += int'(rep_last);
        nplast += int'(rep_pass_last);
      end
      if (pin && rep_valid && rep_idx == 7'd0) chk("pin_first_beat", rep_data, PIN0);
      if (pin && rep_valid && rep_idx == 7'd127) chk("pin_beat_127", rep_data, PIN127);
      tick;
      guard++;
      rep_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
    rep_ready = 1'b0;
    chk("replay_drained_in_budget", exp_rep.size(), 0);
    exp_rep.delete();
    chk("replay_beats", beats, np*DEPTH);
    chk("replay_last_count", nlast, np);
    chk("replay_pass_last_count", nplast, 1);
    chk("replay_end_valid", rep_valid, 1'b0);
    chk("replay_end_full", cap_done, 1'b1);
    chk("replay_end_busy", busy, 1'b0);
  endtask

  task automatic dmx_run(input logic [WW-1:0] w, input bit ident, input bit pin_sat);
    int lat, n, guard;
    for (int k = 0; k < DEPTH; k++) exp_y.push_back(demix(w, mdl_mem[k]));
    w_in = w;
    y_ready = 1'b0;
    dmx_start = 1'b1;
    tick;
    dmx_start = 1'b0;
    w_in = ~w;
    lat = 0;
    while (!y_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk("dmx_first_latency", lat, CH);
    if (ident) begin
      chk("pin_ident_y0", y_out, PIN0);
      y_ready = 1'b1;
      n = 0;
      while (!cap_done && n < 2000) begin
        tick;
        n++;
        w_in = ~w_in;
      end
      chk("dmx_stream_cycles", n, (DEPTH-1)*(CH+1) + 1);
      y_ready = 1'b0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        guard = 0;
        while (!y_valid && guard < 50) begin
          tick;
          guard++;
        end
        if (pin_sat && s == 0) chk("pin_sat_pos", y_out[DW-1:0], 26'h1FFFFFF);
        if (pin_sat && s == 1) chk("pin_sat_neg", y_out[DW-1:0], 26'h2000000);
        repeat ($urandom_range(0, 2)) tick;
        y_ready = 1'b1;
        tick;
        y_ready = 1'b0;
        w_in = ~w_in;
      end
    end
    chk("dmx_drained", exp_y.size(), 0);
    exp_y.delete();
    chk("dmx_end_valid", y_valid, 1'b0);
    chk("dmx_end_full", cap_done, 1'b1);
  endtask

  initial begin
    logic [WW-1:0] w;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cap_done", cap_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rep_valid", rep_valid, 1'b0);
    chk("rst_y_valid", y_valid, 1'b0);
    chk("rst_cmd_err", cmd_err, 1'b0);
    chk("rst_rep_idx", rep_idx, 7'd0);
    chk("rst_rep_data", rep_data, '0);
    chk("rst_y_out", y_out, '0);
    rst = 1'b0;
    tick;

    // Replay request in IDLE is rejected
    rep_passes = 8'd1;
    rep_start = 1'b1;
    tick;
    rep_start = 1'b0;
    chk("idle_rep_cmd_err", cmd_err, 1'b1);
    chk("idle_rep_valid", rep_valid, 1'b0);
    tick;
    chk("idle_cmd_err_pulse", cmd_err, 1'b0);

    // Capture k*16+c with gaps, then stray z_valid while FULL
    cap_start = 1'b1;
    tick;
    cap_start = 1'b0;
    chk("cap_busy", busy, 1'b1);
    chk("cap_not_done", cap_done, 1'b0);
    feed(1'b0);
    z_in = '1;
    z_valid = 1'b1;
    repeat (3) tick;
    z_valid = 1'b0;
    chk("full_after_extra_z", cap_done, 1'b1);
    chk("full_not_busy", busy, 1'b0);

    replay(2, 1'b1, 1'b0);
    replay(0, 1'b0, 1'b1);

    // Identity demix
    w = '0;
    for (int i = 0; i < CH; i++) w[(i*CH+i)*DW +: DW] = 26'h10000;
    dmx_run(w, 1'b1, 1'b0);

    // cap_start wins over rep_start, silently
    cap_start = 1'b1;
    rep_start = 1'b1;
    tick;
    cap_start = 1'b0;
    rep_start = 1'b0;
    chk("arb_cmd_err", cmd_err, 1'b0);
    chk("arb_busy", busy, 1'b1);
    chk("arb_cap_done", cap_done, 1'b0);
    tick;
    chk("arb_no_replay", rep_valid, 1'b0);
    dmx_start = 1'b1;
    tick;
    dmx_start = 1'b0;
    chk("capture_dmx_cmd_err", cmd_err, 1'b1);
    chk("capture_dmx_busy", busy, 1'b1);
    feed(1'b1);

    // Saturating demix with random rows and w_in churn
    w = '0;
    w[0 +: DW] = 26'h1FFFFFF;
    for (int r = 1; r < CH; r++) begin
      for (int j = 0; j < CH; j++) begin
        int v;
        v = int'($urandom_range(0, 32767)) - 16384;
        w[(r*CH+j)*DW +: DW] = DW'(v);
      end
    end
    dmx_run(w, 1'b0, 1'b1);

    // Asynchronous reset during replay
    for (int k = 0; k < DEPTH; k++)
      exp_rep.push_back('{mdl_mem[k], k, k == DEPTH-1, k == DEPTH-1});
    rep_passes = 8'd1;
    rep_ready = 1'b1;
    rep_start = 1'b1;
    tick;
    rep_start = 1'b0;
    repeat (10) tick;
    chk("pre_reset_rep_valid", rep_valid, 1'b1);
    #2;
    exp_rep.delete();
    rst = 1'b1;
    #1;
    chk("async_rst_rep_valid", rep_valid, 1'b0);
    chk("async_rst_cap_done", cap_done, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    rep_ready = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    tick;
    rep_start = 1'b1;
    tick;
    rep_start = 1'b0;
    chk("post_rst_rep_cmd_err", cmd_err, 1'b1);
    chk("post_rst_rep_valid", rep_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "time budget exceeded");
  end

endmodule
